// File: rtl/oyun_pkg.sv
// Shared definitions for the game scorer: FSM state encodings and the point table.
package oyun_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } durum_t;

  // 2-bit points per (X,Y) cell, indexed by {X,Y}; row/column 0 scores nothing.
  localparam logic [31:0] PUAN_TBL = {
    2'd1, 2'd2, 2'd1, 2'd0,   // X=3: Y=3..0
    2'd2, 2'd3, 2'd2, 2'd0,   // X=2
    2'd1, 2'd2, 2'd1, 2'd0,   // X=1
    2'd0, 2'd0, 2'd0, 2'd0    // X=0
  };

endpackage

// File: rtl/oyun_puan.sv
// Combinational point lookup for one player's (X,Y) coordinate pair.
import oyun_pkg::*;

module oyun_puan (
  input  logic [1:0] x,
  input  logic [1:0] y,
  output logic [1:0] p
);

  logic [4:0] idx;

  assign idx = {x, y, 1'b0};
  assign p   = PUAN_TBL[idx +: 2];

endmodule

// File: rtl/oyun_skor.sv
// Round-based game scorer: accumulates round wins and points, decides the game outcome.
import oyun_pkg::*;

module oyun_skor #(
  parameter  int ROUNDS = 3,
  parameter  int NEED   = 2,
  parameter  int THRESH = 5,
  parameter  int EARLY  = 1,
  localparam int CW     = $clog2(ROUNDS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    X1,
  input  logic [1:0]    Y1,
  input  logic [1:0]    X2,
  input  logic [1:0]    Y2,
  output logic          busy,
  output logic          done,
  output logic          O,
  output logic [CW-1:0] wins,
  output logic [CW-1:0] played,
  output logic [6:0]    total
);

  durum_t        state, state_nx;
  logic [1:0]    p1, p2;
  logic [2:0]    sum;
  logic          win, accept, finish;
  logic          won_nx, lost_nx;
  logic [CW-1:0] wins_nx, played_nx;
  logic [4:0]    reach_nx;

  oyun_puan u_puan1 (.x(X1), .y(Y1), .p(p1));
  oyun_puan u_puan2 (.x(X2), .y(Y2), .p(p2));

  assign sum       = {1'b0, p1} + {1'b0, p2};
  assign win       = (sum >= 3'(THRESH));
  assign accept    = in_valid && (state == PLAY);
  assign wins_nx   = wins + CW'(win);
  assign played_nx = played + CW'(1);

  // Best achievable win count if every remaining round were won.
  assign reach_nx  = 5'(wins_nx) + 5'(ROUNDS) - 5'(played_nx);
  assign won_nx    = (5'(wins_nx) >= 5'(NEED));
  assign lost_nx   = (reach_nx < 5'(NEED));
  assign finish    = accept && ((played_nx == CW'(ROUNDS)) ||
                                ((EARLY != 0) && (won_nx || lost_nx)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (start)       state_nx = PLAY;
    else if (finish) state_nx = DONE;
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      PLAY: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // start outranks a same-cycle accept, so that round is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wins   <= '0;
      played <= '0;
      total  <= '0;
      O      <= 1'b0;
    end else if (start) begin
      wins   <= '0;
      played <= '0;
      total  <= '0;
      O      <= 1'b0;
    end else if (accept) begin
      wins   <= wins_nx;
      played <= played_nx;
      total  <= total + {4'b0, sum};
      O      <= finish && won_nx;
    end
  end

endmodule

// File: doc/oyun_skor.md
OYUN_SKOR -- requirements
Module: oyun_skor

Interface
REQ-001 SHALL have parameter ROUNDS, default 3: rounds per game, legal range 1..15.
REQ-002 SHALL have parameter NEED, default 2: round wins required to win the game, legal range 1..ROUNDS.
REQ-003 SHALL have parameter THRESH, default 5: minimum round point sum that counts as a round win, legal range 0..6.
REQ-004 SHALL have parameter EARLY, default 1: 1 ends the game as soon as the outcome is decided; 0 always plays all ROUNDS rounds.
REQ-005 SHALL define CW = $clog2(ROUNDS+1) as the counter width.
REQ-006 SHALL have one clock and an asynchronous, active-low reset.
REQ-007 SHALL have the following ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  clear counters and begin a game
- in_valid  in  1  round data present
- in_ready  out  1  block accepts a round
- X1, Y1  in  2 each  player-1 coordinates
- X2, Y2  in  2 each  player-2 coordinates
- busy  out  1  game in progress
- done  out  1  result valid; level signal
- O  out  1  game won
- wins  out  CW  round wins so far
- played  out  CW  rounds accepted so far
- total  out  7  accumulated round point sums

Function
REQ-008 SHALL compute points per player from a 4x4 table:
- 0 if X=0 or Y=0
- (1,1)=1, (1,2)=2, (1,3)=1
- (2,1)=2, (2,2)=3, (2,3)=2
- (3,1)=1, (3,2)=2, (3,3)=1
REQ-009 SHALL form the round sum p1+p2 (3-bit, 0..6) and mark the round won when sum >= THRESH.
REQ-010 SHALL use an FSM with states IDLE, PLAY and DONE.
REQ-011 SHALL hold in_ready=0, busy=0 and done=0 in IDLE; in_valid SHALL be ignored there.
REQ-012 SHALL, on start=1 in any state, clear wins, played, total and O and enter PLAY on the next edge.
REQ-013 SHALL give start priority over an in_valid accepted in the same cycle; that round is discarded.
REQ-014 SHALL hold in_ready=1 and busy=1 in PLAY.
REQ-015 SHALL accept a round when in_valid & in_ready; per accepted round, played+1, wins+win, total+sum, registered with a 1-cycle latency.
REQ-016 SHALL go from PLAY to DONE on the accepting edge when played_next==ROUNDS.
REQ-017 SHALL, when EARLY=1, also go to DONE when wins_next>=NEED (decided win) or wins_next+(ROUNDS-played_next)<NEED (decided loss).
REQ-018 SHALL, on entering DONE, register O = (wins_next >= NEED); O SHALL be 0 in all other states.
REQ-019 SHALL hold done=1, in_ready=0 and busy=0 in DONE, with all outputs stable until start or reset.
REQ-020 SHALL saturate nothing; the ranges above guarantee no overflow (total <= 90).

Reset
REQ-021 SHALL, on rst_n=0, immediately force state IDLE and in_ready, busy, done, O, wins, played and total to 0.
REQ-022 SHALL apply reset mid-game with the same effect, discarding the game.
REQ-023 SHALL act on the first rising clk edge after rst_n deasserts, never earlier.

Structure
REQ-024 SHALL place the point table constants and the FSM state encodings in shared package oyun_pkg.
REQ-025 SHALL implement the point lookup as sub-module oyun_puan (2+2 bits in, 2 bits out, combinational), instantiated twice.
REQ-026 SHALL keep all state in oyun_skor; oyun_puan SHALL be purely combinational.

Verification
REQ-027 SHALL verify, with defaults, rounds (2,2)/(2,2), (1,1)/(1,1), (2,2)/(1,2) back-to-back -> done after 3rd accept, O=1, wins=2, played=3, total=13.
REQ-028 SHALL verify, with EARLY=1, two rounds of (2,2)/(2,2) -> DONE after round 2, played=2, O=1, in_ready=0; a third in_valid is ignored.
REQ-029 SHALL verify, with EARLY=1, two rounds of (0,0)/(3,3) -> DONE after round 2, O=0, wins=0, total=2.
REQ-030 SHALL verify that in_valid in IDLE is ignored, and that start together with in_valid in PLAY after 1 round gives played=0, wins=0 next cycle.
REQ-031 SHALL verify that rst_n low mid-round, asserted between edges, clears all outputs without a clock edge, and that the FSM re-arms only on start.
REQ-032 SHALL verify, with ROUNDS=3, NEED=2, THRESH=5, EARLY=0, 10^5 random games with random in_valid gaps -> O matches the best-of-3 model with 0 mismatches.
